// File: rtl/aurora_tx_block_framer.sv
`default_nettype none
// ============================================================================
// aurora_tx_block_framer : Aurora 64b66b TX framer (idle/init/CC insertion,
//                          x^58+x^39+1 payload scrambler) feeding the gearbox.
// Optional clock-compensation insertion: define AURORA_TX_CC_EN.
// Rev 1.0
// ============================================================================
module aurora_tx_block_framer #(
    parameter int INIT_IDLES = 16,
    parameter int CC_PERIOD  = 5000,
    parameter int CC_COUNT   = 3,
    parameter int SCRAMBLE   = 1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [63:0] DataIn,
    input  logic [1:0]  HeaderIn,
    input  logic        DataInValid,
    output logic        DataInReady,
    input  logic        DataNext,
    output logic [65:0] Data66,
    output logic        HdrError
);

    localparam logic [63:0] IDLE_BLK = 64'h7800_0000_0000_0000;
    localparam logic [63:0] CC_BLK   = 64'h7880_0000_0000_0000;
    localparam logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

    if (INIT_IDLES < 1 || INIT_IDLES > 255 || CC_COUNT < 1 || CC_COUNT > 15 ||
        CC_PERIOD < CC_COUNT + 1 || CC_PERIOD > 65536) begin : g_bad_params
        $error("aurora_tx_block_framer: parameter out of range");
    end

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  init_cnt;
    logic [57:0] scr_state;
    logic [57:0] scr_work;
    logic [57:0] scr_next;
    logic [63:0] scr_payload;
    logic [63:0] sel_payload;
    logic [1:0]  sel_header;
    logic        transfer;
    logic        hdr_legal;
    logic        emit_cc;

`ifdef AURORA_TX_CC_EN
    logic [15:0] blk_cnt;
    logic [3:0]  cc_cnt;
    logic        cc_due;

    assign emit_cc     = (state == ST_RUN) && cc_due;
    assign DataInReady = DataNext && (state == ST_RUN) && !cc_due;
`else
    assign emit_cc     = 1'b0;
    assign DataInReady = DataNext && (state == ST_RUN);
`endif

    assign transfer  = DataInValid && DataInReady;
    assign hdr_legal = (HeaderIn == 2'b01) || (HeaderIn == 2'b10);

    always_comb begin
        sel_payload = IDLE_BLK;
        sel_header  = 2'b10;
        if (emit_cc) begin
            sel_payload = CC_BLK;
        end else if (transfer) begin
            sel_payload = DataIn;
            sel_header  = hdr_legal ? HeaderIn : 2'b10;
        end
    end

    // Bit-serial scrambler unrolled over the 64 payload bits, LSB first.
    always_comb begin
        scr_work    = scr_state;
        scr_payload = '0;
        for (int i = 0; i < 64; i++) begin
            scr_payload[i] = sel_payload[i] ^ scr_work[38] ^ scr_work[57];
            scr_work       = {scr_work[56:0], scr_payload[i]};
        end
        scr_next = scr_work;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            scr_state <= SCR_SEED;
            Data66    <= {2'b10, IDLE_BLK};
            HdrError  <= 1'b0;
`ifdef AURORA_TX_CC_EN
            blk_cnt   <= '0;
            cc_cnt    <= '0;
            cc_due    <= 1'b0;
`endif
        end else begin
            if (transfer && !hdr_legal) begin
                HdrError <= 1'b1;
            end
            if (DataNext) begin
                scr_state <= scr_next;
                Data66    <= {sel_header, (SCRAMBLE != 0) ? scr_payload : sel_payload};
                case (state)
                    ST_INIT: begin
                        if (init_cnt == 8'(INIT_IDLES - 1)) begin
                            state    <= ST_RUN;
                            init_cnt <= '0;
                        end else begin
                            init_cnt <= init_cnt + 8'd1;
                        end
                    end
                    ST_RUN: begin
`ifdef AURORA_TX_CC_EN
                        // A burst starts at blk_cnt 0 and ends before the next wrap.
                        if (blk_cnt == 16'(CC_PERIOD - 1)) begin
                            blk_cnt <= '0;
                            cc_due  <= 1'b1;
                        end else begin
                            blk_cnt <= blk_cnt + 16'd1;
                        end
                        if (cc_due) begin
                            if (cc_cnt == 4'(CC_COUNT - 1)) begin
                                cc_cnt <= '0;
                                cc_due <= 1'b0;
                            end else begin
                                cc_cnt <= cc_cnt + 4'd1;
                            end
                        end
`endif
                    end
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_block_framer.sv
`default_nettype none
// Testbench for aurora_tx_block_framer: an unscrambled and a scrambled instance
// share stimulus and are checked against a block-level reference model.
module tb_aurora_tx_block_framer;

    localparam int INIT_N = 4;
    localparam int PERIOD = 20;
    localparam int CCN    = 3;
`ifdef AURORA_TX_CC_EN
    localparam bit CC_ON = 1'b1;
`else
    localparam bit CC_ON = 1'b0;
`endif
    localparam logic [63:0] IDLE = 64'h7800_0000_0000_0000;
    localparam logic [63:0] CCB  = 64'h7880_0000_0000_0000;
    localparam logic [65:0] RST_BLK = {2'b10, 64'h7800_0000_0000_0000};

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [63:0] DataIn = '0;
    logic [1:0]  HeaderIn = 2'b01;
    logic        DataInValid = 1'b0;
    logic        DataNext = 1'b0;
    logic        rdy0, rdy1, err0, err1;
    logic [65:0] d0, d1;

    always #5 Clk = ~Clk;

    aurora_tx_block_framer #(.INIT_IDLES(INIT_N), .CC_PERIOD(PERIOD), .CC_COUNT(CCN), .SCRAMBLE(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .HeaderIn(HeaderIn), .DataInValid(DataInValid),
        .DataInReady(rdy0), .DataNext(DataNext), .Data66(d0), .HdrError(err0));

    aurora_tx_block_framer #(.INIT_IDLES(INIT_N), .CC_PERIOD(PERIOD), .CC_COUNT(CCN), .SCRAMBLE(1)) dut1 (
        .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .HeaderIn(HeaderIn), .DataInValid(DataInValid),
        .DataInReady(rdy1), .DataNext(DataNext), .Data66(d1), .HdrError(err1));

    int total = 0;
    int bad   = 0;

    // Reference model: block count since reset, scrambler state, expected outputs.
    int          m_n;
    logic [57:0] m_s;
    logic [65:0] m_exp0, m_exp1;
    logic        m_err;
    logic        exp_rdy;
    logic        m_xfer;
    logic [1:0]  obs_rdy;

    function automatic bit is_cc(input int k);
        return CC_ON && (k >= PERIOD) && ((k % PERIOD) < CCN);
    endfunction

    function automatic bit model_ready();
        return (m_n >= INIT_N) && !is_cc(m_n - INIT_N);
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_s    = 58'h3FF_FFFF_FFFF_FFFF;
        m_exp0 = RST_BLK;
        m_exp1 = RST_BLK;
        m_err  = 1'b0;
    endtask

    task automatic model_advance(input logic xfer, input logic [1:0] h, input logic [63:0] d);
        logic [63:0] p, sp;
        logic [1:0]  hd;
        p  = IDLE;
        hd = 2'b10;
        if (m_n >= INIT_N && is_cc(m_n - INIT_N)) begin
            p = CCB;
        end else if (xfer) begin
            p = d;
            if (h == 2'b01 || h == 2'b10) hd = h;
            else m_err = 1'b1;
        end
        for (int i = 0; i < 64; i++) begin
            sp[i] = p[i] ^ m_s[38] ^ m_s[57];
            m_s   = {m_s[56:0], sp[i]};
        end
        m_exp0 = {hd, p};
        m_exp1 = {hd, sp};
        m_n++;
    endtask

    // One clock: drive at negedge, sample ready, then advance the model at posedge.
    task automatic drive(input logic nxt, input logic vld, input logic [1:0] h, input logic [63:0] d);
        @(negedge Clk);
        DataNext    = nxt;
        DataInValid = vld;
        HeaderIn    = h;
        DataIn      = d;
        #1;
        exp_rdy = nxt && model_ready();
        obs_rdy = {rdy1, rdy0};
        m_xfer  = exp_rdy && vld;
        @(posedge Clk);
        if (nxt) model_advance(m_xfer, h, d);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        DataNext = 1'b0;
        DataInValid = 1'b0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Rst = 1'b1;
        model_reset();
        DataNext = 1'b1;
        DataInValid = 1'b1;
        #1;
        total++; if (d0 !== RST_BLK) begin bad++; $display("FAIL reset_d66_plain got=%h exp=%h", d0, RST_BLK); end
        total++; if (d1 !== RST_BLK) begin bad++; $display("FAIL reset_d66_scr got=%h exp=%h", d1, RST_BLK); end
        total++; if ({err1, err0} !== 2'b00) begin bad++; $display("FAIL reset_hdrerr got=%b exp=00", {err1, err0}); end
        total++; if ({rdy1, rdy0} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {rdy1, rdy0}); end
        @(negedge Clk);
        DataNext = 1'b0;
        DataInValid = 1'b0;
        Rst = 1'b0;
    endtask

    task automatic test_init();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(i[0] == 1'b0, 1'b1, 2'b01, {$urandom, $urandom});
            total++; if (obs_rdy !== {2{exp_rdy}}) begin bad++; $display("FAIL init_ready cyc=%0d got=%b exp=%b", i, obs_rdy, exp_rdy); end
            total++; if (d0 !== m_exp0) begin bad++; $display("FAIL init_d66 cyc=%0d got=%h exp=%h", i, d0, m_exp0); end
            total++; if (d1 !== m_exp1) begin bad++; $display("FAIL init_d66_scr cyc=%0d got=%h exp=%h", i, d1, m_exp1); end
        end
    endtask

    task automatic test_fixed_block();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive(1'b1, 1'b1, 2'b01, 64'hDEAD_BEEF_0123_4567);
            if (m_xfer) begin
                done = 1;
                total++; if (d0 !== 66'h1_DEAD_BEEF_0123_4567) begin bad++; $display("FAIL fixed_block got=%h exp=%h", d0, 66'h1_DEAD_BEEF_0123_4567); end
                total++; if (d1 !== m_exp1) begin bad++; $display("FAIL fixed_block_scr got=%h exp=%h", d1, m_exp1); end
            end
        end
        total++; if (!done) begin bad++; $display("FAIL fixed_block_timeout got=no_transfer exp=transfer"); end
    endtask

    task automatic test_scramble_zero();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 2'b01, 64'd0);
            total++; if (d1 !== m_exp1) begin bad++; $display("FAIL scr_zero cyc=%0d got=%h exp=%h", i, d1, m_exp1); end
            if (m_xfer) begin
                total++; if (d1[65:64] !== 2'b01) begin bad++; $display("FAIL scr_zero_hdr cyc=%0d got=%b exp=01", i, d1[65:64]); end
            end
        end
    endtask

    task automatic test_cc();
        logic [63:0] seq_in = 64'h100;
        logic [63:0] seq_out = 64'h100;
        int cc_seen = 0, cc_exp = 0;
        do_reset();
        for (int i = 0; i < 90; i++) begin
            drive(1'b1, 1'b1, 2'b01, seq_in);
            if (m_xfer) seq_in++;
            if (m_n > INIT_N && is_cc(m_n - 1 - INIT_N)) cc_exp++;
            if (d0 === {2'b10, CCB}) cc_seen++;
            total++; if (obs_rdy !== {2{exp_rdy}}) begin bad++; $display("FAIL cc_ready cyc=%0d got=%b exp=%b", i, obs_rdy, exp_rdy); end
            if (d0[65:64] === 2'b01) begin
                total++; if (d0[63:0] !== seq_out) begin bad++; $display("FAIL cc_user_seq cyc=%0d got=%h exp=%h", i, d0[63:0], seq_out); end
                seq_out = d0[63:0] + 64'd1;
            end
            total++; if (d1 !== m_exp1) begin bad++; $display("FAIL cc_d66_scr cyc=%0d got=%h exp=%h", i, d1, m_exp1); end
        end
        total++; if (cc_seen != cc_exp) begin bad++; $display("FAIL cc_count got=%0d exp=%0d", cc_seen, cc_exp); end
        total++; if (seq_out != seq_in) begin bad++; $display("FAIL cc_user_total got=%h exp=%h", seq_out, seq_in); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10,
                  {$urandom, $urandom});
            total++; if (obs_rdy !== {2{exp_rdy}}) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, obs_rdy, exp_rdy); end
            total++; if ({d1, d0} !== {m_exp1, m_exp0}) begin bad++; $display("FAIL rand_d66 cyc=%0d got=%h/%h exp=%h/%h", i, d0, d1, m_exp0, m_exp1); end
            total++; if ({err1, err0} !== 2'b00) begin bad++; $display("FAIL rand_hdrerr cyc=%0d got=%b exp=00", i, {err1, err0}); end
        end
    endtask

    task automatic test_hdr_error();
        bit done = 0;
        do_reset();
        for (int i = 0; i < 40 && !done; i++) begin
            drive(1'b1, 1'b1, 2'b11, 64'hA5A5_0000_1234_5678);
            if (m_xfer) begin
                done = 1;
                total++; if (d0 !== {2'b10, 64'hA5A5_0000_1234_5678}) begin bad++; $display("FAIL hdr_illegal_block got=%h exp=%h", d0, {2'b10, 64'hA5A5_0000_1234_5678}); end
                total++; if (d1 !== m_exp1) begin bad++; $display("FAIL hdr_illegal_scr got=%h exp=%h", d1, m_exp1); end
            end else begin
                total++; if ({err1, err0} !== 2'b00) begin bad++; $display("FAIL hdr_err_early cyc=%0d got=%b exp=00", i, {err1, err0}); end
            end
        end
        total++; if (!done) begin bad++; $display("FAIL hdr_timeout got=no_transfer exp=transfer"); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 2'b01, {$urandom, $urandom});
            total++; if ({err1, err0} !== {2{m_err}}) begin bad++; $display("FAIL hdr_sticky cyc=%0d got=%b exp=%b", i, {err1, err0}, m_err); end
        end
        do_reset();
        #1;
        total++; if ({err1, err0} !== 2'b00) begin bad++; $display("FAIL hdr_clear got=%b exp=00", {err1, err0}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 25; i++) drive(1'b1, 1'b1, 2'b01, {$urandom, $urandom});
        #3;
        Rst = 1'b1;
        model_reset();
        #1;
        total++; if (d0 !== RST_BLK) begin bad++; $display("FAIL midrst_d66 got=%h exp=%h", d0, RST_BLK); end
        total++; if (d1 !== RST_BLK) begin bad++; $display("FAIL midrst_d66_scr got=%h exp=%h", d1, RST_BLK); end
        @(negedge Clk);
        DataNext = 1'b0;
        Rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 2'b01, {$urandom, $urandom});
            total++; if (obs_rdy !== {2{exp_rdy}}) begin bad++; $display("FAIL midrst_ready cyc=%0d got=%b exp=%b", i, obs_rdy, exp_rdy); end
            total++; if ({d1, d0} !== {m_exp1, m_exp0}) begin bad++; $display("FAIL midrst_d66_after cyc=%0d got=%h/%h exp=%h/%h", i, d0, d1, m_exp0, m_exp1); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_init();
        test_fixed_block();
        test_scramble_zero();
        test_cc();
        test_random();
        test_hdr_error();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
